// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - issue/retire sequencer around a multi-cycle unsigned divider
// Optional one-entry result cache enabled by defining DIV_RESULT_CACHE_EN.
module div_sequencer #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic [31:0]      div_nume,
  output logic [31:0]      div_den,
  output logic             div_en,
  output logic             div_clr,
  input  logic             div_done,
  input  logic [31:0]      div_quotient,
  input  logic [31:0]      div_remainder
);
  typedef enum logic [2:0] {CLR, IDLE, ISSUE, WAIT, RESP} state_e;

  state_e           state_q;
  logic             rem_q, neg_q_q, neg_r_q, abort_q;
  logic [31:0]      mag_a_q, mag_b_q, data_q;
  logic [TAG_W-1:0] tag_q;

  logic        sgn, accept, special, hit;
  logic [31:0] abs_a, abs_b, special_data, hit_data, q_fix, r_fix;

  always_comb begin
    sgn   = ~req_op[0];
    abs_a = (sgn && req_a[31]) ? -req_a : req_a;
    abs_b = (sgn && req_b[31]) ? -req_b : req_b;
    special = (req_b == 32'h0) ||
              (sgn && req_a == 32'h8000_0000 && req_b == 32'hFFFF_FFFF);
    // Divide-by-zero wins over overflow; overflow needs b = -1, never 0.
    if (req_b == 32'h0) special_data = req_op[1] ? req_a : 32'hFFFF_FFFF;
    else                special_data = req_op[1] ? 32'h0 : 32'h8000_0000;
    q_fix = neg_q_q ? -div_quotient  : div_quotient;
    r_fix = neg_r_q ? -div_remainder : div_remainder;
  end

  assign accept = (state_q == IDLE) && req_valid && !flush;

`ifdef DIV_RESULT_CACHE_EN
  logic        c_valid_q, c_sgn_q, op_sgn_q;
  logic [31:0] c_a_q, c_b_q, c_quo_q, c_rem_q, op_a_q, op_b_q;

  assign hit      = c_valid_q && c_a_q == req_a && c_b_q == req_b && c_sgn_q == sgn;
  assign hit_data = req_op[1] ? c_rem_q : c_quo_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      c_valid_q <= 1'b0;
      c_sgn_q   <= 1'b0;
      op_sgn_q  <= 1'b0;
      c_a_q     <= 32'h0;
      c_b_q     <= 32'h0;
      c_quo_q   <= 32'h0;
      c_rem_q   <= 32'h0;
      op_a_q    <= 32'h0;
      op_b_q    <= 32'h0;
    end else begin
      if (accept) begin
        op_a_q   <= req_a;
        op_b_q   <= req_b;
        op_sgn_q <= sgn;
      end
      if ((state_q == ISSUE || state_q == WAIT) && flush) begin
        c_valid_q <= 1'b0;
      end else if (state_q == WAIT && div_done) begin
        c_valid_q <= 1'b1;
        c_a_q     <= op_a_q;
        c_b_q     <= op_b_q;
        c_sgn_q   <= op_sgn_q;
        c_quo_q   <= q_fix;
        c_rem_q   <= r_fix;
      end
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = 32'h0;
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= CLR;
      rem_q   <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      abort_q <= 1'b0;
      mag_a_q <= 32'h0;
      mag_b_q <= 32'h0;
      data_q  <= 32'h0;
      tag_q   <= '0;
    end else begin
      abort_q <= 1'b0;
      case (state_q)
        CLR: state_q <= IDLE;
        IDLE: begin
          if (accept) begin
            rem_q   <= req_op[1];
            tag_q   <= req_tag;
            neg_q_q <= sgn && (req_a[31] ^ req_b[31]);
            neg_r_q <= sgn && req_a[31];
            mag_a_q <= abs_a;
            mag_b_q <= abs_b;
            if (special) begin
              data_q  <= special_data;
              state_q <= RESP;
            end else if (hit) begin
              data_q  <= hit_data;
              state_q <= RESP;
            end else begin
              state_q <= ISSUE;
            end
          end
        end
        ISSUE, WAIT: begin
          if (flush) begin
            abort_q <= 1'b1;
            state_q <= IDLE;
          end else if (state_q == ISSUE) begin
            state_q <= WAIT;
          end else if (div_done) begin
            data_q  <= rem_q ? r_fix : q_fix;
            state_q <= RESP;
          end
        end
        RESP: if (flush || resp_ready) state_q <= IDLE;
        default: state_q <= CLR;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign div_en     = (state_q == ISSUE);
  assign div_clr    = (state_q == CLR) || abort_q;
  assign resp_data  = data_q;
  assign resp_tag   = tag_q;
  assign div_nume   = mag_a_q;
  assign div_den    = mag_b_q;
endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - directed bench for div_sequencer with arithmetic reference model
// Honours DIV_RESULT_CACHE_EN when defined for the build.
module tb_div_sequencer;
  localparam int TAG_W = 5;
`ifdef DIV_RESULT_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic             clk, clr_n;
  logic             req_valid, req_ready, flush, resp_valid, resp_ready;
  logic [1:0]       req_op;
  logic [31:0]      req_a, req_b, resp_data, div_nume, div_den, div_quotient, div_remainder;
  logic [TAG_W-1:0] req_tag, resp_tag;
  logic             div_en, div_clr, div_done;

  int checks = 0, errors = 0, en_cnt = 0, div_lat = 2;
  logic             exp_valid = 1'b0, exp_div = 1'b0;
  logic [31:0]      exp_data = 32'h0, exp_nume = 32'h0, exp_den = 32'h0;
  logic [TAG_W-1:0] exp_tag = '0;
  logic             mc_valid = 1'b0, mc_s = 1'b0;
  logic [31:0]      mc_a = 32'h0, mc_b = 32'h0;

  div_sequencer #(.TAG_W(TAG_W)) dut (
    .clk(clk), .clr_n(clr_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .div_nume(div_nume), .div_den(div_den), .div_en(div_en),
    .div_clr(div_clr), .div_done(div_done), .div_quotient(div_quotient),
    .div_remainder(div_remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in unsigned divider: busy for div_lat cycles after a start pulse.
  logic        fd_busy = 1'b0;
  int          fd_cnt  = 0;
  logic [31:0] fd_q = 32'h0, fd_r = 32'h0;
  always @(posedge clk) begin
    if (div_clr) fd_busy <= 1'b0;
    else if (div_en) begin
      fd_busy <= 1'b1;
      fd_cnt  <= div_lat;
      fd_q    <= div_nume / div_den;
      fd_r    <= div_nume % div_den;
    end else if (fd_busy) begin
      if (fd_cnt <= 1) fd_busy <= 1'b0;
      else fd_cnt <= fd_cnt - 1;
    end
  end
  assign div_done      = ~fd_busy;
  assign div_quotient  = fd_q;
  assign div_remainder = fd_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic s;
    s = ~op[0];
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
    if (s) return op[1] ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
    return op[1] ? a % b : a / b;
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] x, input logic s);
    return (s && $signed(x) < 0) ? 32'h0 - x : x;
  endfunction

  always @(negedge clk) begin
    if (clr_n) begin
      if (resp_valid) begin
        if (!exp_valid) chk("spurious_resp_valid", 32'(resp_valid), 32'h0);
        else begin
          chk("resp_data", resp_data, exp_data);
          chk("resp_tag", 32'(resp_tag), 32'(exp_tag));
        end
      end
      if (div_en || fd_busy) begin
        chk("div_nume", div_nume, exp_nume);
        chk("div_den", div_den, exp_den);
      end
      if (div_en) en_cnt++;
    end
  end

  task automatic accept_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [TAG_W-1:0] tag);
    int n;
    logic s, special, hit;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    @(posedge clk);
    #1 req_valid = 1'b0;
    s       = ~op[0];
    special = (b == 32'h0) || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    hit     = CACHE_EN && !special && mc_valid && mc_a == a && mc_b == b && mc_s == s;
    exp_div = !special && !hit;
    if (exp_div) begin mc_valid = 1'b1; mc_a = a; mc_b = b; mc_s = s; end
    exp_data  = model(op, a, b);
    exp_tag   = tag;
    exp_nume  = mag(a, s);
    exp_den   = mag(b, s);
    exp_valid = 1'b1;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input logic [31:0] lit, input int hold);
    int lat, en0;
    chk("model_pin", model(op, a, b), lit);
    en0 = en_cnt;
    accept_req(op, a, b, tag);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_valid && lat < 100);
    chk("resp_latency", 32'(lat), exp_div ? 32'(div_lat + 3) : 32'h1);
    chk("resp_data_lit", resp_data, lit);
    chk("div_en_pulses", 32'(en_cnt - en0), exp_div ? 32'h1 : 32'h0);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_resp_valid", 32'(resp_valid), 32'h1);
      chk("hold_req_ready", 32'(req_ready), 32'h0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    exp_valid = 1'b0;
    @(negedge clk);
    chk("post_resp_valid", 32'(resp_valid), 32'h0);
    chk("post_req_ready", 32'(req_ready), 32'h1);
  endtask

  task automatic check_clr_outputs;
    chk("clr_req_ready", 32'(req_ready), 32'h0);
    chk("clr_resp_valid", 32'(resp_valid), 32'h0);
    chk("clr_div_en", 32'(div_en), 32'h0);
    chk("clr_div_clr", 32'(div_clr), 32'h1);
    chk("clr_resp_data", resp_data, 32'h0);
    chk("clr_resp_tag", 32'(resp_tag), 32'h0);
  endtask

  initial begin
    clr_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_a = 32'h0; req_b = 32'h0;
    req_tag = '0; flush = 1'b0; resp_ready = 1'b0;
    #1 check_clr_outputs();
    @(negedge clk) clr_n = 1'b1;
    @(negedge clk) chk("idle_req_ready", 32'(req_ready), 32'h1);

    run_op(2'b01, 32'd100, 32'd7, 5'd3, 32'd14, 0);
    div_lat = 4;
    run_op(2'b10, 32'hFFFF_FF9C, 32'd7, 5'd9, 32'hFFFF_FFFE, 0);
    run_op(2'b00, 32'd100, 32'hFFFF_FFF9, 5'd17, 32'hFFFF_FFF2, 1);
    run_op(2'b00, 32'd5, 32'd0, 5'd1, 32'hFFFF_FFFF, 0);
    run_op(2'b11, 32'd5, 32'd0, 5'd2, 32'd5, 0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd30, 32'h8000_0000, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd31, 32'h0, 0);
    run_op(2'b01, 32'd1000, 32'd10, 5'd12, 32'd100, 10);

    // Flush while the divider is busy.
    div_lat = 8;
    accept_req(2'b01, 32'd50, 32'd5, 5'd4);
    @(negedge clk); @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    exp_valid = 1'b0; mc_valid = 1'b0;
    @(negedge clk) chk("flush_div_clr", 32'(div_clr), 32'h1);
    @(negedge clk) chk("flush_div_clr_end", 32'(div_clr), 32'h0);
    repeat (12) @(negedge clk);
    chk("flush_req_ready", 32'(req_ready), 32'h1);

    // Asynchronous reset in the middle of a divide.
    accept_req(2'b01, 32'd60, 32'd6, 5'd6);
    @(negedge clk); @(negedge clk);
    #2 clr_n = 1'b0;
    exp_valid = 1'b0; mc_valid = 1'b0;
    #1 check_clr_outputs();
    @(negedge clk) clr_n = 1'b1;
    repeat (12) @(negedge clk);
    div_lat = 3;
    run_op(2'b01, 32'd9, 32'd3, 5'd21, 32'd3, 0);

    // Flush while a response is held, and flush in IDLE blocking acceptance.
    accept_req(2'b00, 32'd5, 32'd0, 5'd7);
    @(negedge clk) chk("resp_before_flush", 32'(resp_valid), 32'h1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    exp_valid = 1'b0;
    @(negedge clk) chk("flush_resp_drop", 32'(resp_valid), 32'h0);
    req_valid = 1'b1; flush = 1'b1; req_op = 2'b01; req_a = 32'd7; req_b = 32'd7;
    @(posedge clk);
    #1 begin req_valid = 1'b0; flush = 1'b0; end
    @(negedge clk) chk("flush_idle_blocked", 32'(req_ready), 32'h1);
    repeat (4) @(negedge clk);

    run_op(2'b00, 32'd100, 32'd7, 5'd10, 32'd14, 0);
    run_op(2'b10, 32'd100, 32'd7, 5'd11, 32'd2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
